// File: rtl/servant_loader_pkg.sv
// Shared types and constants for the servant boot loader.
// The CSUM state is only reachable when SERVANT_LOADER_CHECKSUM_EN is defined.
package servant_loader_pkg;
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam logic [1:0] MEM_REGION = 2'b00;
endpackage

// File: rtl/servant_wb_loader_if.sv
// Write-only Wishbone initiator port of the loader (CPU-side interconnect port).
interface servant_wb_loader_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input ack);
  modport slave  (input adr, dat, sel, we, cyc, output ack);
endinterface

// File: rtl/servant_byte_packer.sv
// Assembles four bytes into a little-endian word; strobes on the 4th byte.
module servant_byte_packer (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_done,
  output logic [31:0] o_word
);
  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // The word already includes the byte being accepted, so the strobe cycle sees it complete.
  always_comb begin
    o_word = r_word;
    o_word[{r_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word_done = i_en && (r_idx == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_en) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= o_word;
    end
  end
endmodule

// File: rtl/servant_wb_loader.sv
// Boot loader: byte stream -> sequential Wishbone word writes, holds the CPU in reset until done.
// Optional trailing XOR checksum byte when SERVANT_LOADER_CHECKSUM_EN is defined.
module servant_wb_loader
  import servant_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  servant_wb_loader_if.master io_wb,
  output logic                o_cpu_rst,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);
`ifdef SERVANT_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = CSUM;
  localparam bit     CSUM_EN = 1'b1;
`else
  localparam state_t S_FINAL = DONE;
  localparam bit     CSUM_EN = 1'b0;
`endif

  state_t                 r_state, w_state_nxt;
  logic                   r_cyc;
  logic [31:0]            r_adr;
  logic [31:0]            r_dat;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   w_acc;
  logic                   w_pack_en;
  logic                   w_word_done;
  logic [31:0]            w_word;
  logic                   w_clr;

  assign o_rx_ready = (r_state == HDR) || (r_state == DATA) || (CSUM_EN && (r_state == CSUM));
  assign w_acc      = i_rx_valid && o_rx_ready;
  assign w_pack_en  = w_acc && ((r_state == HDR) || (r_state == DATA));
  // Byte index restarts on every state entry.
  assign w_clr      = i_rst || (w_state_nxt != r_state);

  servant_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_clr       (w_clr),
    .i_en        (w_pack_en),
    .i_byte      (i_rx_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

`ifdef SERVANT_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_ok;

  assign w_csum_ok = (i_rx_data == r_csum);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_csum <= 8'd0;
    else if ((r_state == DATA) && w_acc)
      r_csum <= r_csum ^ i_rx_data;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR: if (w_word_done) begin
        if (w_word == 32'd0)
          w_state_nxt = S_FINAL;
        else if (w_word > 32'(MAX_WORDS))
          w_state_nxt = ERR;
        else
          w_state_nxt = DATA;
      end
      DATA:  if (w_word_done) w_state_nxt = WRITE;
      WRITE: if (io_wb.ack) w_state_nxt = (r_cnt == CNT_WIDTH'(1)) ? S_FINAL : DATA;
`ifdef SERVANT_LOADER_CHECKSUM_EN
      CSUM:  if (w_acc) w_state_nxt = w_csum_ok ? DONE : ERR;
`endif
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= HDR;
      r_cyc   <= 1'b0;
      r_adr   <= BASE_ADR;
      r_dat   <= 32'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // cyc tracks WRITE exactly, so it drops in the same update that consumes the ack.
      r_cyc   <= (w_state_nxt == WRITE);
      if ((r_state == HDR) && w_word_done)
        r_cnt <= w_word[CNT_WIDTH-1:0];
      if ((r_state == DATA) && w_word_done)
        r_dat <= w_word;
      if ((r_state == WRITE) && io_wb.ack) begin
        r_adr <= r_adr + 32'd4;
        r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
    end
  end

  assign io_wb.adr = r_adr;
  assign io_wb.dat = r_dat;
  assign io_wb.sel = WB_SEL_ALL;
  assign io_wb.we  = 1'b1;
  assign io_wb.cyc = r_cyc;

  assign o_done    = (r_state == DONE);
  assign o_err     = (r_state == ERR);
  assign o_cpu_rst = (r_state != DONE);
  assign o_busy    = (r_state == DATA) || (r_state == WRITE) || (r_state == CSUM);
endmodule

// File: tb/tb_servant_wb_loader.sv
// Randomized bench for servant_wb_loader against an image-level reference model.
// Honours SERVANT_LOADER_CHECKSUM_EN to append/verify the trailing checksum byte.
module tb_servant_wb_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MAXW = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready, cpu_rst, busy, done, err;

  servant_wb_loader_if wb ();

  servant_wb_loader #(.BASE_ADR(BASE), .MAX_WORDS(MAXW), .CNT_WIDTH(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .io_wb      (wb),
    .o_cpu_rst  (cpu_rst),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Interconnect model: registered ack one cycle after cyc, never re-acked back to back.
  always @(posedge clk) wb.ack <= !rst && wb.cyc && !wb.ack;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: completed writes, cyc run lengths, bytes offered while cyc is high.
  logic [31:0] got_adr[$];
  logic [31:0] got_dat[$];
  int          cyc_q[$];
  int          cyc_run = 0;
  int          viol = 0;

  always @(negedge clk) begin
    if (wb.cyc && wb.ack) begin
      got_adr.push_back(wb.adr);
      got_dat.push_back(wb.dat);
    end
    if (wb.cyc) cyc_run++;
    else if (cyc_run != 0) begin
      cyc_q.push_back(cyc_run);
      cyc_run = 0;
    end
    if (wb.cyc && rx_ready) viol++;
  end

  task automatic clear_mon();
    got_adr.delete();
    got_dat.delete();
    cyc_q.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gate);
    int t;
    if (gate) while ($urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      if (++t > 200) begin
        chk("byte_accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Builds a stream: header, payload, checksum byte (flipped when bad_csum) in checksum builds.
  task automatic build_image(input logic [31:0] n, input int words, input bit bad_csum,
                             output logic [7:0] img[$]);
    logic [7:0] x;
    logic [7:0] b;
    img.delete();
    x = 8'd0;
    for (int i = 0; i < 4; i++) img.push_back(n[8*i +: 8]);
    for (int i = 0; i < 4 * words; i++) begin
      b = 8'($urandom);
      x ^= b;
      img.push_back(b);
    end
`ifdef SERVANT_LOADER_CHECKSUM_EN
    if (n <= MAXW) img.push_back(bad_csum ? ~x : x);
`else
    if (bad_csum) x = 8'd0;
`endif
  endtask

  task automatic wait_end();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done || err) return;
    end
    chk("end_timeout", 32'd0, 32'd1);
  endtask

  // Reference: expected writes and outcome derived from the stream bytes alone.
  task automatic check_image(input string tag, input logic [7:0] img[$]);
    logic [31:0] n;
    logic        e_err;
    int          nw;
    logic [7:0]  x;
    n = {img[3], img[2], img[1], img[0]};
    e_err = (n > MAXW);
    nw = e_err ? 0 : int'(n);
`ifdef SERVANT_LOADER_CHECKSUM_EN
    if (!e_err) begin
      x = 8'd0;
      for (int i = 4; i < 4 + 4 * nw; i++) x ^= img[i];
      e_err = (img[4 + 4 * nw] != x);
    end
`else
    x = 8'd0;
`endif
    chk({tag, "_nwr"}, got_adr.size(), nw);
    for (int i = 0; i < nw && i < got_adr.size(); i++) begin
      chk({tag, "_adr"}, got_adr[i], BASE + 32'(4 * i));
      chk({tag, "_dat"}, got_dat[i], {img[4+4*i+3], img[4+4*i+2], img[4+4*i+1], img[4+4*i]});
    end
    foreach (cyc_q[i]) chk({tag, "_cyclen"}, cyc_q[i], 2);
    chk({tag, "_viol"}, viol, 0);
    chk({tag, "_done"}, done, !e_err);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_cpurst"}, cpu_rst, e_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, rx_ready, 0);
  endtask

  task automatic run_image(input string tag, input logic [7:0] img[$], input bit gate, input bit rs);
    if (rs) do_reset();
    foreach (img[i]) send_byte(img[i], gate);
    wait_end();
    repeat (3) @(negedge clk);
    check_image(tag, img);
  endtask

  logic [7:0] img[$];

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_adr", wb.adr, BASE);
    chk("rst_dat", wb.dat, 0);
    chk("rst_sel_we", {wb.sel, wb.we}, 5'b11111);
    chk("rst_cpurst", cpu_rst, 1);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_rdy", rx_ready, 1);

    // Single word DE AD BE EF
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef SERVANT_LOADER_CHECKSUM_EN
    img.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    run_image("one", img, 1'b0, 1'b1);
    chk("one_dat_const", got_dat.size() > 0 ? got_dat[0] : 32'h0, 32'hEFBEADDE);
    chk("one_cyc_runs", cyc_q.size(), 1);

    // Gated random multi-word images
    for (int k = 0; k < 6; k++) begin
      int nwd;
      nwd = $urandom_range(1, 4);
      build_image(32'(nwd), nwd, 1'b0, img);
      run_image("rand", img, 1'b1, 1'b1);
    end

    // Empty image
    build_image(32'd0, 0, 1'b0, img);
    run_image("n0", img, 1'b0, 1'b1);
    chk("n0_nocyc", cyc_q.size(), 0);

    // Oversize headers, boundary and random
    build_image(32'(MAXW + 1), 0, 1'b0, img);
    run_image("big", img, 1'b0, 1'b1);
    chk("big_nocyc", cyc_q.size(), 0);
    build_image(32'(MAXW + 1) + $urandom_range(0, 100000), 0, 1'b0, img);
    run_image("bigr", img, 1'b1, 1'b1);

    // Exactly MAX_WORDS is accepted
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'(MAXW >> (8 * i)), 1'b0);
    @(negedge clk);
    chk("max_busy", busy, 1);
    chk("max_err", err, 0);

    // Sticky DONE ignores further input
    build_image(32'd1, 1, 1'b0, img);
    run_image("stk", img, 1'b0, 1'b1);
    rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("stk_done", {done, rx_ready, wb.cyc}, 3'b100);
    rx_valid = 1'b0;

`ifdef SERVANT_LOADER_CHECKSUM_EN
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_image("cs_ok", img, 1'b0, 1'b1);
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_image("cs_bad", img, 1'b0, 1'b1);
    build_image(32'd3, 3, 1'b1, img);
    run_image("cs_rbad", img, 1'b1, 1'b1);
`endif

    // Reset while the 2nd of 3 words is on the bus
    do_reset();
    build_image(32'd3, 3, 1'b0, img);
    for (int i = 0; i < 12; i++) send_byte(img[i], 1'b0);
    chk("mid_cyc_hi", wb.cyc, 1);
    chk("mid_wr1", got_adr.size(), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_cyc_lo", wb.cyc, 0);
    chk("mid_adr", wb.adr, BASE);
    chk("mid_hdr", {rx_ready, busy, cpu_rst}, 3'b101);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_mon();
    build_image(32'd1, 1, 1'b0, img);
    run_image("mid_new", img, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/servant_wb_loader.md
Name: servant_wb_loader

Overview:
- Wishbone initiator that drives the CPU-side port of the servant bus interconnect in place of the CPU during boot.
- Receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and writes them sequentially into the memory region.
- Holds the CPU in reset until the image is complete, then releases it.

Parameters:
- BASE_ADR, 32'h0000_0000: byte address of the first word written. Must lie in the memory region, bits [31:30] = 2'b00.
- MAX_WORDS, 2048: largest accepted word count. A header above this is an error.
- CNT_WIDTH, 16: width of the internal word counter. Must satisfy 2^CNT_WIDTH > MAX_WORDS.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_rx_data  in  8  stream byte
- i_rx_valid  in  1  byte valid
- o_rx_ready  out  1  byte accepted when valid & ready
- o_wb_adr  out  32  Wishbone address
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte select, constant 4'hF
- o_wb_we  out  1  constant 1
- o_wb_cyc  out  1  cycle/strobe
- i_wb_ack  in  1  registered ack from interconnect
- o_cpu_rst  out  1  CPU reset hold
- o_busy  out  1  load in progress (header received, not done/err)
- o_done  out  1  image loaded
- o_err  out  1  load failed

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk. i_rst takes priority over all other events.
- Reset values: o_wb_cyc=0, o_wb_adr=BASE_ADR, o_wb_dat=0, o_cpu_rst=1, o_busy=0, o_done=0, o_err=0, state=HDR.
- Stream format: 4-byte little-endian word count N, then 4N payload bytes, each word little-endian (first byte -> dat[7:0]).
- o_rx_ready is combinational: 1 only in HDR and DATA. A byte transfers on the edge where i_rx_valid & o_rx_ready.
- Byte index: 2-bit counter, cleared on every state entry. Wraps 3->0 as the 4th byte completes a word.
- FSM state HDR:
  - Collect 4 bytes into N.
  - On the 4th byte: N=0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA, o_busy=1, word counter=N.
- FSM state DATA:
  - Collect 4 bytes into o_wb_dat.
  - On the 4th byte, next cycle: o_wb_cyc=1, state WRITE.
- FSM state WRITE:
  - o_wb_adr/o_wb_dat stable while cyc=1. No bytes are accepted.
  - On the edge where i_wb_ack=1: o_wb_cyc->0 in the same registered update, o_wb_adr += 4 (modulo 2^32), counter -= 1.
  - Counter reaching 0 -> DONE (or CSUM when the optional feature is compiled in); else -> DATA.
  - cyc must never be high in the cycle after ack: the interconnect re-acks a held cycle.
- Ack timing: with the interconnect, ack arrives 1 cycle after cyc rises, so each word costs 4 byte-cycles + 2 bus cycles.
- i_wb_ack while o_wb_cyc=0 is ignored.
- FSM state DONE: o_cpu_rst=0, o_done=1, o_busy=0, o_rx_ready=0. Sticky until i_rst.
- FSM state ERR: o_err=1, o_busy=0, o_cpu_rst stays 1, o_rx_ready=0. Sticky until i_rst.
- Reset mid-WRITE: cyc drops on the reset edge and the partial word is abandoned. No retry.
- The stream stalling at any byte boundary is legal; there is no timeout.

Optional Feature:
- Macro: SERVANT_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of all payload bytes is kept; header bytes are excluded.
  - After the last word's ack, enter CSUM (o_rx_ready=1) and accept 1 byte.
  - Byte == XOR -> DONE, else -> ERR.
  - For N=0 the checksum byte is still expected, compared against 8'h00.
- Undefined: no CSUM state, no XOR register. o_err is raised only by the oversize-header error.

Decomposition:
- Shared package servant_loader_pkg holds:
  - state enum HDR/DATA/WRITE/CSUM/DONE/ERR;
  - constants WB_SEL_ALL=4'hF and MEM_REGION=2'b00.
- One natural sub-module, servant_byte_packer: 2-bit index plus 32-bit shift/assemble register with a clear input. It emits a word-complete strobe and the assembled word. Used for both the header and the data words.

Test Plan:
- Bytes 01 00 00 00, DE AD BE EF with 1-cycle ack -> one write: adr=BASE_ADR, dat=32'hEFBEADDE, cyc high exactly 2 cycles; then o_done=1, o_cpu_rst=0.
- N=3 with i_rx_valid gated 50% randomly -> writes to BASE_ADR, +4, +8 with the correct words; no byte accepted while cyc=1.
- Header N=0 -> DONE immediately after the 4th header byte, no cyc asserted (checksum build: after checksum byte 00).
- Header N=MAX_WORDS+1 (00 08 00 00 with default 2048 -> 2049 = 01 08 00 00) -> o_err=1, o_cpu_rst=1, o_rx_ready=0, no cyc.
- i_rst asserted while o_wb_cyc=1 on the 2nd of 3 words -> cyc=0 next edge, adr=BASE_ADR, state HDR; a fresh N=1 image then loads correctly.
- Checksum build: N=1, payload 11 22 33 44, checksum 44 -> DONE; repeat with checksum 45 -> ERR.
